// File: rtl/mul_intf_if.sv
// Operand/result handshake bundle for the sequential 8x8 multiplier.
// The producer or consumer side uses master; the multiplier uses slave.
interface mul_intf_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/mul_intf.sv
// Sequential 8x8 unsigned multiplier: radix-2 shift-add over eight cycles.
// Valid/ready handshakes are used on both the operand side and the result side.
module mul_intf (
    input  logic       clk,
    input  logic       rst_n,
    mul_intf_if.slave  bus,
    output logic [1:0] state_dbg
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // Valid does not depend on ready. Operands are sampled only on the accepting edge.
    // The result is held in y until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] a_reg;
    logic [7:0]  b_reg;
    logic [15:0] acc;
    logic [2:0]  cnt;
    logic [15:0] y_reg;
    logic        in_ready_reg;
    logic        out_valid_reg;
    logic [15:0] acc_next;

    // The add for the current edge is visible here, so the last CALC edge can load y with it.
    always_comb begin
        acc_next = acc;
        if (b_reg[0]) begin
            acc_next = acc + a_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            a_reg         <= 16'd0;
            b_reg         <= 8'd0;
            acc           <= 16'd0;
            cnt           <= 3'd0;
            y_reg         <= 16'd0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg        <= {8'd0, bus.a};
                        b_reg        <= bus.b;
                        acc          <= 16'd0;
                        cnt          <= 3'd0;
                        in_ready_reg <= 1'b0;
                        state        <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        y_reg         <= acc_next;
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.y         = y_reg;
    assign state_dbg     = state;
endmodule

// File: tb/tb_mul_intf.sv
// Self-checking bench for mul_intf: a cycle-level reference model with a result queue,
// plus directed vectors that have hand-computed products and latencies.
module tb_mul_intf;
    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;

    mul_intf_if bus ();

    mul_intf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: "idle" means operands are accepted, and "valid" means a product is waiting.
    logic [15:0] exp_q[$];
    logic        m_idle  = 1'b1;
    logic        m_valid = 1'b0;
    logic [15:0] m_y     = 16'd0;
    logic [15:0] m_pend  = 16'd0;
    int          cyc     = 0;
    int          done_at = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_loop();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                m_idle  = 1'b1;
                m_valid = 1'b0;
                m_y     = 16'd0;
            end else begin
                cyc++;
                if (m_idle && bus.in_valid) begin
                    m_pend  = 16'(int'(bus.a) * int'(bus.b));
                    exp_q.push_back(m_pend);
                    done_at = cyc + 8;
                    m_idle  = 1'b0;
                end else if (!m_idle && !m_valid && cyc == done_at) begin
                    m_valid = 1'b1;
                    m_y     = m_pend;
                end else if (m_valid && bus.out_ready) begin
                    m_valid = 1'b0;
                    m_idle  = 1'b1;
                end
            end
        end
    endtask

    // Compare every cycle, well away from both clock edges.
    task automatic compare_loop();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            #2;
            check("in_ready", 32'(bus.in_ready), 32'(m_idle));
            check("out_valid", 32'(bus.out_valid), 32'(m_valid));
            check("y", 32'(bus.y), 32'(m_y));
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_product", 32'(bus.y), 32'(e));
                end
            end
        end
    endtask

    // Driver: one operation with directed operands, expected product, backpressure and optional noise
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int unsigned exp_y,
                         input int hold, input bit noise);
        int wd;
        int lat;
        wd = 0;
        while (!bus.in_ready && wd < 20) begin
            @(negedge clk);
            wd++;
        end
        check("wait_in_ready", 32'(bus.in_ready), 1);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 8'($urandom_range(0, 255));
        bus.b        = 8'($urandom_range(0, 255));
        check("busy_in_ready", 32'(bus.in_ready), 0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            if (noise) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.a        = 8'($urandom_range(0, 255));
                bus.b        = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            lat++;
            if (!bus.out_valid) check("calc_in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0;
        check("latency", lat, 8);
        check("y_literal", 32'(bus.y), exp_y);
        repeat (hold) begin
            @(negedge clk);
            check("hold_out_valid", 32'(bus.out_valid), 1);
            check("hold_in_ready", 32'(bus.in_ready), 0);
            check("hold_y", 32'(bus.y), exp_y);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_in_ready", 32'(bus.in_ready), 1);
        check("post_out_valid", 32'(bus.out_valid), 0);
        check("post_y_kept", 32'(bus.y), exp_y);
    endtask

    initial begin
        int wd;
        int last_acc;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = 8'd0;
        bus.b         = 8'd0;
        bus.out_ready = 1'b0;
        fork
            model_loop();
            compare_loop();
        join_none

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_y", 32'(bus.y), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_start", 32'(bus.in_ready), 1);

        do_op(8'd12, 8'd13, 156, 0, 1'b0);
        do_op(8'd0, 8'd200, 0, 0, 1'b0);
        do_op(8'd255, 8'd255, 16'hFE01, 0, 1'b0);
        do_op(8'd1, 8'd255, 255, 0, 1'b0);
        do_op(8'd128, 8'd2, 256, 0, 1'b0);
        do_op(8'd7, 8'd9, 63, 5, 1'b0);
        do_op(8'd50, 8'd60, 3000, 0, 1'b1);
        repeat (2) @(negedge clk);
        check("no_extra_op", 32'(bus.out_valid), 0);
        check("no_extra_idle", 32'(bus.in_ready), 1);

        // Abort an operation partway through the calculation.
        bus.a        = 8'd200;
        bus.b        = 8'd100;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_in_ready", 32'(bus.in_ready), 1);
        check("async_rst_out_valid", 32'(bus.out_valid), 0);
        check("async_rst_y", 32'(bus.y), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(8'd3, 8'd4, 12, 0, 1'b0);

        // Back-to-back stream with the consumer always ready
        bus.out_ready = 1'b1;
        last_acc = 0;
        for (int i = 0; i < 20; i++) begin
            bus.a        = 8'($urandom_range(0, 255));
            bus.b        = 8'($urandom_range(0, 255));
            bus.in_valid = 1'b1;
            wd = 0;
            while (!bus.in_ready && wd < 40) begin
                @(negedge clk);
                wd++;
            end
            check("stream_wait", 32'(bus.in_ready), 1);
            if (i > 0) check("stream_period", cyc - last_acc, 10);
            last_acc = cyc;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        wd = 0;
        while (!(bus.in_ready && exp_q.size() == 0) && wd < 40) begin
            @(negedge clk);
            wd++;
        end
        check("drain_done", 32'(exp_q.size()), 0);
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
